// File: rtl/vga_text_driver.sv
// 640x480@60 VGA timing, character-buffer read addressing, two-stage pin pipeline.
// Define VGA_TEXT_DRIVER_CLKDIV2_EN to run from a 2x pixel clock.
module vga_text_driver #(
    parameter logic [11:0] p_fg_rgb = 12'hFFF,
    parameter logic [11:0] p_bg_rgb = 12'h000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] read_hchar,
    output logic [5:0] read_vchar,
    output logic [2:0] read_hoffset,
    output logic [2:0] read_voffset,
    input  logic       read_lit,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start
);

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd752;
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd492;
    localparam logic [9:0] V_LAST   = 10'd524;

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        tick;
    logic        active, hsync_n, vsync_n, sof;
    logic        act_s1_q, hs_s1_q, vs_s1_q, sof_s1_q;
    logic        hs_q, vs_q, fs_q;
    logic [11:0] rgb_q, rgb_d;

`ifdef VGA_TEXT_DRIVER_CLKDIV2_EN
    logic phase_q, phase_d;

    assign phase_d = ~phase_q;
    assign tick    = phase_q;

    always_ff @(posedge clk) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign active  = (hcount_q < H_ACTIVE) && (vcount_q < V_ACTIVE);
    assign hsync_n = !((hcount_q >= H_SYNC_S) && (hcount_q < H_SYNC_E));
    assign vsync_n = !((vcount_q >= V_SYNC_S) && (vcount_q < V_SYNC_E));
    assign sof     = (hcount_q == 10'd0) && (vcount_q == 10'd0);

    // Out-of-range cell addresses make the buffer return unlit in blanking.
    assign read_hchar   = active ? hcount_q[9:3] : 7'd127;
    assign read_vchar   = active ? vcount_q[8:3] : 6'd63;
    assign read_hoffset = hcount_q[2:0];
    assign read_voffset = vcount_q[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
            sof_s1_q <= 1'b0;
        end else begin
            act_s1_q <= active;
            hs_s1_q  <= hsync_n;
            vs_s1_q  <= vsync_n;
            sof_s1_q <= sof;
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        if (act_s1_q) rgb_d = read_lit ? p_fg_rgb : p_bg_rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
            rgb_q <= 12'h000;
        end else begin
            hs_q  <= hs_s1_q;
            vs_q  <= vs_s1_q;
            fs_q  <= sof_s1_q;
            rgb_q <= rgb_d;
        end
    end

    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign frame_start = fs_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_text_driver.sv
// Scoreboard bench for vga_text_driver against a linear pixel-index model.
// Counter jumps into the vertical regions keep the run short.
`timescale 1ns/1ps
module tb_vga_text_driver;

`ifdef VGA_TEXT_DRIVER_CLKDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam logic [11:0] FG = 12'hA5C;
    localparam logic [11:0] BG = 12'h312;
    localparam int FRAME = 800 * 525;

    typedef struct packed {
        logic [6:0] hc;
        logic [5:0] vc;
        logic [2:0] ho;
        logic [2:0] vo;
    } addr_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } pins_t;

    localparam pins_t RST_PINS = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 12'h000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] read_hchar;
    logic [5:0] read_vchar;
    logic [2:0] read_hoffset, read_voffset;
    logic       read_lit = 1'b0;
    logic       vga_hsync, vga_vsync, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;

    vga_text_driver #(.p_fg_rgb(FG), .p_bg_rgb(BG)) dut (
        .clk(clk), .rst(rst),
        .read_hchar(read_hchar), .read_vchar(read_vchar),
        .read_hoffset(read_hoffset), .read_voffset(read_voffset),
        .read_lit(read_lit),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    checking = 1'b0;
    bit    lit_tab [1024];
    logic  force_lit = 1'b0;
    int    pix = 0;
    bit    ph = 1'b0;
    logic [9:0] jump_h, jump_v;
    addr_t exp_addr_q [$];
    pins_t exp_pins_q [$];

    function automatic int idx(input addr_t a);
        return (int'(a.hc) * 13 + int'(a.vc) * 7 + int'(a.ho) * 3 + int'(a.vo)) % 1024;
    endfunction

    function automatic addr_t exp_addr(input int p);
        int h, v;
        addr_t r;
        h = p % 800;
        v = p / 800;
        if (h < 640 && v < 480) begin
            r.hc = 7'(h / 8);
            r.vc = 6'(v / 8);
        end else begin
            r.hc = 7'd127;
            r.vc = 6'd63;
        end
        r.ho = 3'(h % 8);
        r.vo = 3'(v % 8);
        return r;
    endfunction

    function automatic pins_t exp_pins(input int p, input logic frc);
        int h, v;
        bit act, lit;
        pins_t r;
        h = p % 800;
        v = p / 800;
        act = (h < 640) && (v < 480);
        lit = frc || lit_tab[idx(exp_addr(p))];
        r.hs = !(h >= 656 && h < 752);
        r.vs = !(v >= 490 && v < 492);
        r.fs = (p == 0);
        r.rgb = act ? (lit ? FG : BG) : 12'h000;
        return r;
    endfunction

    // Character buffer: one-cycle read latency, unlit for out-of-range cells.
    always @(posedge clk) begin
        if (force_lit)
            read_lit <= 1'b1;
        else if (read_hchar < 7'd80 && read_vchar < 6'd60)
            read_lit <= lit_tab[idx({read_hchar, read_vchar, read_hoffset, read_voffset})];
        else
            read_lit <= 1'b0;
    end

    // Called at posedge+1; sets this cycle's inputs and pushes expectations.
    task automatic step(input bit do_rst, input int jump);
        if (jump >= 0) begin
            jump_h = 10'(jump % 800);
            jump_v = 10'(jump / 800);
            force dut.hcount_q = jump_h;
            force dut.vcount_q = jump_v;
            release dut.hcount_q;
            release dut.vcount_q;
            pix = jump;
        end
        force_lit = ($urandom_range(0, 7) == 0);
        rst = do_rst;
        exp_addr_q.push_back(exp_addr(pix));
        if (do_rst) begin
            void'(exp_pins_q.pop_back());
            exp_pins_q.push_back(RST_PINS);
            exp_pins_q.push_back(RST_PINS);
            pix = 0;
            ph = 1'b0;
        end else begin
            exp_pins_q.push_back(exp_pins(pix, force_lit));
            if (DIV == 1 || ph) pix = (pix + 1) % FRAME;
            ph = !ph;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int pixels);
        for (int i = 0; i < pixels * DIV; i++) begin
            if (errors > 100) break;
            step(1'b0, -1);
        end
    endtask

    int since_rst = 0;
    always @(posedge clk) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    logic prev_hs = 1'b1, prev_vs = 1'b1;
    bit   fall_pending = 1'b1, hs_track = 1'b0, vs_track = 1'b0;
    int   hs_len = 0, vs_len = 0;

    always @(negedge clk) begin : monitor
        addr_t ga, ea;
        pins_t gp, ep;
        if (checking) begin
            ga = {read_hchar, read_vchar, read_hoffset, read_voffset};
            gp = {vga_hsync, vga_vsync, frame_start, vga_r, vga_g, vga_b};
            checks++;
            if (exp_addr_q.size() == 0 || exp_pins_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t got nothing to compare, want queued entry", $time);
            end else begin
                ea = exp_addr_q.pop_front();
                ep = exp_pins_q.pop_front();
                if (ga !== ea) begin
                    errors++;
                    $display("FAIL addr t=%0t got hc=%0d vc=%0d ho=%0d vo=%0d want hc=%0d vc=%0d ho=%0d vo=%0d",
                             $time, ga.hc, ga.vc, ga.ho, ga.vo, ea.hc, ea.vc, ea.ho, ea.vo);
                end
                checks++;
                if (gp !== ep) begin
                    errors++;
                    $display("FAIL pins t=%0t got hs=%b vs=%b fs=%b rgb=%h want hs=%b vs=%b fs=%b rgb=%h",
                             $time, gp.hs, gp.vs, gp.fs, gp.rgb, ep.hs, ep.vs, ep.fs, ep.rgb);
                end
            end
            if (rst) begin
                fall_pending = 1'b1;
                hs_track = 1'b0;
                vs_track = 1'b0;
            end
            if (prev_hs && !vga_hsync) begin
                if (fall_pending) begin
                    checks++;
                    if (since_rst != 656 * DIV + 2) begin
                        errors++;
                        $display("FAIL hsync_first_fall got %0d clocks want %0d", since_rst, 656 * DIV + 2);
                    end
                    fall_pending = 1'b0;
                end
                hs_len = 0;
                hs_track = 1'b1;
            end
            if (!prev_hs && vga_hsync && hs_track) begin
                checks++;
                if (hs_len != 96 * DIV) begin
                    errors++;
                    $display("FAIL hsync_width got %0d clocks want %0d", hs_len, 96 * DIV);
                end
            end
            if (!vga_hsync) hs_len++;
            if (prev_vs && !vga_vsync) begin
                vs_len = 0;
                vs_track = 1'b1;
            end
            if (!prev_vs && vga_vsync && vs_track) begin
                checks++;
                if (vs_len != 2 * 800 * DIV) begin
                    errors++;
                    $display("FAIL vsync_width got %0d clocks want %0d", vs_len, 2 * 800 * DIV);
                end
            end
            if (!vga_vsync) vs_len++;
            prev_hs = vga_hsync;
            prev_vs = vga_vsync;
        end
    end

    initial begin
        foreach (lit_tab[i]) lit_tab[i] = 1'($urandom_range(0, 1));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_pins_q.push_back(RST_PINS);
        exp_pins_q.push_back(RST_PINS);
        checking = 1'b1;
        run(1700);
        step(1'b0, 479 * 800 + 100);
        run(2000 - 1);
        step(1'b0, 489 * 800 + 100);
        run(2600 - 1);
        step(1'b0, 524 * 800 + 100);
        run(1500 - 1);
        step(1'b0, 200 * 800 + 250);
        run(50 - 1);
        step(1'b1, -1);
        run(1700);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_driver.md
# vga_text_driver

- Generates 640x480 @ 60 Hz VGA timing for the text console.
- Issues per-pixel character-cell read requests to the character buffer's read port, and turns the returned lit bit (one-cycle read latency) into colour output.
- Pipeline-aligns the sync signals with that colour output.
- Sits between the character buffer and the board's VGA pins; it is the only reader of the buffer.

## Interface
Parameters:
- p_fg_rgb, 12'hFFF: {R,G,B} 4 bits each, driven for lit pixels
- p_bg_rgb, 12'h000: {R,G,B} driven for unlit active pixels

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  system clock; 25.175 MHz pixel clock, or 2x that with the divider enabled
- rst  in  1  synchronous active-high reset
- read_hchar  out  7  character column, hcount[9:3]; 127 outside the active area
- read_vchar  out  6  character row, vcount[8:3]; 63 outside the active area
- read_hoffset  out  3  hcount[2:0]
- read_voffset  out  3  vcount[2:0]
- read_lit  in  1  buffer pixel, valid one clk after the address
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_r, vga_g, vga_b  out  4 each  colour, zero in blanking
- frame_start  out  1  one-pixel pulse aligned with output pixel (0,0)

## Operation
- Pixel tick:
  - Without the divider: every clock.
  - With the divider: every second clock.
- hcount (10 bit), 0..799 on each tick:
  - Wraps to 0 after 799.
  - Advances vcount on wrap.
- vcount (10 bit), 0..524; wraps to 0 after 524.
- Active area is hcount < 640 and vcount < 480.
- Horizontal regions: active 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- Vertical regions: active 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- Read addresses are combinational from the counters:
  - In the active area: read_hchar = hcount[9:3], read_vchar = vcount[8:3].
  - Otherwise forced to 127 and 63, which are out of range so the buffer returns unlit.
  - Offsets are always the low 3 bits.
- Stage 1 registers, each clock, from the counters: active_d1, hsync_d1, vsync_d1, sof_d1 (hcount==0 && vcount==0).
- Stage 2 output registers, each clock:
  - hsync/vsync/frame_start ← stage 1 values.
  - rgb ← active_d1 ? (read_lit ? p_fg_rgb : p_bg_rgb) : 0.
- No state machine beyond the two counters and the divider phase bit.

## Timing
- Reset values:
  - hcount = 0, vcount = 0, divider phase = 0.
  - All stage registers cleared; sync stage registers reset to 1 (inactive).
  - Outputs: vga_hsync = 1, vga_vsync = 1, rgb = 0, frame_start = 0.
  - Read addresses read 0/0/0/0 the first cycle after reset.
- Address-to-pin latency:
  - A counter value presented at clock edge N appears on the VGA pins after edge N+2.
  - read_lit is sampled at edge N+1, per the buffer's one-cycle latency.
- Sync and colour always share the same latency, so there is no relative skew.
- Reset asserted mid-frame takes effect at the next edge. Outputs return to their reset values and the frame restarts at (0,0); a partial frame is acceptable.
- vsync transitions coincide with the hcount 799→0 wrap, i.e. the line boundary.
- Frame period is 800×525 = 420000 ticks.
- The counters never reach an out-of-range value; there are no illegal states.

## Configuration
- VGA_TEXT_DRIVER_CLKDIV2_EN defined:
  - A phase bit toggles every clock; counters advance only when phase = 1.
  - Each pixel's address is held 2 clocks, and the outputs follow 2 clocks later.
  - Every output pixel lasts 2 clocks; frame = 840000 clocks.
  - Sized for a 50.35 MHz clk.
- VGA_TEXT_DRIVER_CLKDIV2_EN undefined:
  - No phase bit; counters advance every clock.
  - Frame = 420000 clocks.

## Test plan
- Reset then run 1 line (divider off) → hsync low for exactly 96 clocks, falling 658 clocks after reset release (656 + 2 pipeline); line period 800 clocks.
- Run 2 frames → vsync low for exactly 2×800 clocks per frame; frame_start pulses every 420000 clocks, high 1 clock each, coincident with the first active pixel.
- Buffer model returns read_lit = (read_hoffset==0) with 1-cycle latency → rgb = 12'hFFF on every 8th active pixel, 12'h000 on the other active pixels, 0 throughout blanking.
- At hcount = 640 and at vcount = 480 → read_hchar = 127 and read_vchar = 63 respectively; rgb = 0 two clocks later even if read_lit forced 1.
- Assert rst at hcount = 300, vcount = 200 for 1 clock → next cycle outputs at reset values, read addresses 0; hsync falls again 658 clocks after release.
- Divider macro defined → hsync low 192 clocks, line 1600 clocks, frame_start period 840000, each read address held exactly 2 clocks.
